// File: rtl/shot_scheduler_if.sv
// Shot scheduler bus: frame tick, fire key, slot status in; launch pulses and status out.
interface shot_scheduler_if #(
    parameter int unsigned NUM_SHOTS = 8
);
    localparam int unsigned CNT_W = $clog2(NUM_SHOTS) + 1;

    logic                 startOfFrame;
    logic                 shoot;
    logic                 player_active;
    logic [NUM_SHOTS-1:0] shots_active;
    logic [NUM_SHOTS-1:0] deploy_shot;
    logic                 busy;
    logic [CNT_W-1:0]     free_count;

    // Environment side: drives the fire controls and observes launches.
    modport master (
        output startOfFrame, shoot, player_active, shots_active,
        input  deploy_shot, busy, free_count
    );

    // Scheduler side.
    modport slave (
        input  startOfFrame, shoot, player_active, shots_active,
        output deploy_shot, busy, free_count
    );
endinterface

// File: rtl/shot_scheduler.sv
// Shot scheduler: turns a fire-key press into a one-clock launch pulse to a free
// shot slot (round-robin), then enforces a cooldown measured in video frames.
module shot_scheduler #(
    parameter int unsigned NUM_SHOTS       = 8,
    parameter int unsigned COOLDOWN_FRAMES = 8
) (
    input  logic               clk,
    input  logic               resetN,
    shot_scheduler_if.slave    bus
);
    localparam int unsigned PTR_W = $clog2(NUM_SHOTS);
    localparam int unsigned CNT_W = $clog2(NUM_SHOTS) + 1;
    localparam int unsigned FRM_W = 8;

    typedef enum logic [1:0] {IDLE, WAIT_SLOT, FIRE, COOLDOWN} state_t;

    state_t               state, state_nxt;
    logic                 shoot_d;
    logic [NUM_SHOTS-1:0] reserved, reserved_nxt;
    logic [PTR_W-1:0]     ptr, ptr_nxt;
    logic [PTR_W-1:0]     sel, sel_nxt;
    logic [FRM_W-1:0]     frame_cnt, frame_cnt_nxt;
    logic [NUM_SHOTS-1:0] deploy_q, deploy_nxt;
    logic                 busy_q, busy_nxt;
    logic [CNT_W-1:0]     free_count_q;

    logic                 press_c;
    logic [NUM_SHOTS-1:0] free_c;
    logic [PTR_W-1:0]     rr_sel_c;
    logic [PTR_W-1:0]     rr_idx_c;
    logic                 rr_found_c;
    logic [CNT_W-1:0]     free_pop_c;

    assign press_c = bus.shoot & ~shoot_d;
    assign free_c  = ~bus.shots_active & ~reserved;

    // First free slot at or after ptr, wrapping around the pool.
    always_comb begin
        rr_found_c = 1'b0;
        rr_sel_c   = ptr;
        rr_idx_c   = '0;
        for (int unsigned k = 0; k < NUM_SHOTS; k++) begin
            rr_idx_c = ptr + PTR_W'(k);
            if (!rr_found_c && free_c[rr_idx_c]) begin
                rr_sel_c   = rr_idx_c;
                rr_found_c = 1'b1;
            end
        end
    end

    // Number of currently free slots.
    always_comb begin
        free_pop_c = '0;
        for (int unsigned k = 0; k < NUM_SHOTS; k++) begin
            free_pop_c = free_pop_c + CNT_W'(free_c[k]);
        end
    end

    // Next-state and registered-output logic; a launch reservation beats a same-cycle clear.
    always_comb begin
        state_nxt     = state;
        sel_nxt       = sel;
        ptr_nxt       = ptr;
        frame_cnt_nxt = frame_cnt;
        deploy_nxt    = '0;
        reserved_nxt  = reserved & ~bus.shots_active & ~{NUM_SHOTS{bus.startOfFrame}};
        case (state)
            IDLE: begin
                if (press_c && bus.player_active) begin
                    state_nxt = WAIT_SLOT;
                end
            end
            WAIT_SLOT: begin
                if (!bus.player_active) begin
                    state_nxt = IDLE;
                end else if (rr_found_c) begin
                    state_nxt = FIRE;
                    sel_nxt   = rr_sel_c;
                end
            end
            FIRE: begin
                deploy_nxt         = NUM_SHOTS'(1) << sel;
                reserved_nxt[sel]  = 1'b1;
                ptr_nxt            = sel + PTR_W'(1);
                if (COOLDOWN_FRAMES == 32'd0) begin
                    state_nxt = IDLE;
                end else begin
                    state_nxt     = COOLDOWN;
                    frame_cnt_nxt = FRM_W'(COOLDOWN_FRAMES);
                end
            end
            COOLDOWN: begin
                if (frame_cnt == '0) begin
                    state_nxt = IDLE;
                end else if (bus.startOfFrame) begin
                    frame_cnt_nxt = frame_cnt - FRM_W'(1);
                    if (frame_cnt == FRM_W'(1)) begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
        busy_nxt = (state_nxt != IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state        <= IDLE;
            shoot_d      <= 1'b0;
            reserved     <= '0;
            ptr          <= '0;
            sel          <= '0;
            frame_cnt    <= '0;
            deploy_q     <= '0;
            busy_q       <= 1'b0;
            free_count_q <= CNT_W'(NUM_SHOTS);
        end else begin
            state        <= state_nxt;
            shoot_d      <= bus.shoot;
            reserved     <= reserved_nxt;
            ptr          <= ptr_nxt;
            sel          <= sel_nxt;
            frame_cnt    <= frame_cnt_nxt;
            deploy_q     <= deploy_nxt;
            busy_q       <= busy_nxt;
            free_count_q <= free_pop_c;
        end
    end

    assign bus.deploy_shot = deploy_q;
    assign bus.busy        = busy_q;
    assign bus.free_count  = free_count_q;
endmodule

// File: tb/tb_shot_scheduler.sv
// Bench for shot_scheduler: directed scenarios with literal expectations plus
// a randomized run, all checked every cycle against a behavioural model.
module tb_shot_scheduler;
    localparam int N  = 8;
    localparam int CF = 8;

    logic clk = 1'b0;
    logic resetN = 1'b1;
    always #5 clk = ~clk;

    shot_scheduler_if #(.NUM_SHOTS(N)) bus();

    shot_scheduler #(.NUM_SHOTS(N), .COOLDOWN_FRAMES(CF)) dut (
        .clk    (clk),
        .resetN (resetN),
        .bus    (bus)
    );

    int checks   = 0;
    int failures = 0;
    bit started  = 0;
    int pulses   = 0;
    logic [N-1:0] last_dep = '0;

    // Behavioural model: pending request, scheduled launch slot, frames left to wait.
    bit          m_prev_shoot = 0;
    bit          m_wait = 0;
    int          m_pend = -1;
    int          m_cool = 0;
    bit          m_res [N];
    int          m_ptr = 0;
    logic [N-1:0] exp_dep = '0;
    bit          exp_busy = 0;
    int          exp_fc = N;
    bit          fr [N];
    bit          pr;
    int          nfree;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            m_prev_shoot = 0; m_wait = 0; m_pend = -1; m_cool = 0; m_ptr = 0;
            for (int i = 0; i < N; i++) m_res[i] = 0;
            exp_dep = '0; exp_busy = 0; exp_fc = N;
        end else begin
            nfree = 0;
            for (int i = 0; i < N; i++) begin
                fr[i] = !bus.shots_active[i] && !m_res[i];
                if (fr[i]) nfree++;
            end
            pr = bus.shoot && !m_prev_shoot;
            m_prev_shoot = bus.shoot;
            exp_dep = '0;
            for (int i = 0; i < N; i++)
                if (bus.shots_active[i] || bus.startOfFrame) m_res[i] = 0;
            if (m_pend >= 0) begin
                exp_dep[m_pend] = 1'b1;
                m_res[m_pend] = 1;
                m_ptr = (m_pend + 1) % N;
                m_cool = CF;
                m_pend = -1;
            end else if (m_wait) begin
                if (!bus.player_active) m_wait = 0;
                else if (nfree > 0) begin
                    for (int k = N - 1; k >= 0; k--)
                        if (fr[(m_ptr + k) % N]) m_pend = (m_ptr + k) % N;
                    m_wait = 0;
                end
            end else if (m_cool > 0) begin
                if (bus.startOfFrame) m_cool--;
            end else if (pr && bus.player_active) begin
                m_wait = 1;
            end
            exp_fc = nfree;
            exp_busy = m_wait || (m_pend >= 0) || (m_cool > 0);
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (started) begin
            check("deploy_shot", 32'(bus.deploy_shot), 32'(exp_dep));
            check("busy", 32'(bus.busy), 32'(exp_busy));
            check("free_count", 32'(bus.free_count), 32'(exp_fc));
        end
    end

    // Launch pulse tally.
    always @(negedge clk) begin
        if (bus.deploy_shot != '0) begin
            pulses++;
            last_dep = bus.deploy_shot;
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press();
        bus.shoot = 1'b1;
        step(1);
        bus.shoot = 1'b0;
    endtask

    task automatic frame();
        bus.startOfFrame = 1'b1;
        step(1);
        bus.startOfFrame = 1'b0;
        step(3);
    endtask

    task automatic do_reset();
        bus.shoot = 1'b0; bus.startOfFrame = 1'b0;
        bus.player_active = 1'b1; bus.shots_active = '0;
        #1 resetN = 1'b0;
        #1;
        check("rst_deploy", 32'(bus.deploy_shot), 32'h0);
        check("rst_busy", 32'(bus.busy), 32'h0);
        check("rst_free_count", 32'(bus.free_count), 32'd8);
        step(2);
        resetN = 1'b1;
        started = 1;
        step(1);
    endtask

    int p0;

    initial begin
        bus.shoot = 1'b0; bus.startOfFrame = 1'b0;
        bus.player_active = 1'b1; bus.shots_active = '0;
        step(1);

        // Basic launch: slot 0, two clocks after the press is sampled.
        do_reset();
        p0 = pulses;
        bus.shoot = 1'b1;
        step(1); check("basic_busy", 32'(bus.busy), 32'h1);
        step(1); check("basic_early", 32'(bus.deploy_shot), 32'h0);
        step(1); check("basic_deploy", 32'(bus.deploy_shot), 32'h01);
        step(1); check("basic_after", 32'(bus.deploy_shot), 32'h0);
        check("basic_free_count", 32'(bus.free_count), 32'd7);
        bus.shoot = 1'b0;

        // All slots busy: hold in wait, then slot 5 frees.
        do_reset();
        p0 = pulses;
        bus.shots_active = 8'hFF;
        press();
        step(5);
        check("wait_busy", 32'(bus.busy), 32'h1);
        check("wait_no_deploy", 32'(pulses - p0), 32'd0);
        bus.shots_active = 8'hDF;
        step(2);
        check("slot5_deploy", 32'(bus.deploy_shot), 32'h20);
        step(1);

        // Cooldown: press after 3 frames ignored; press after 8 frames goes to slot 1.
        do_reset();
        p0 = pulses;
        press(); step(4);
        repeat (3) frame();
        press(); step(4);
        check("cooldown_one", 32'(pulses - p0), 32'd1);
        repeat (5) frame();
        press(); step(4);
        check("cooldown_two", 32'(pulses - p0), 32'd2);
        check("cooldown_slot1", 32'(last_dep), 32'h02);

        // Held key for 20 frames gives one launch.
        do_reset();
        p0 = pulses;
        bus.shoot = 1'b1;
        repeat (20) frame();
        bus.shoot = 1'b0;
        step(3);
        check("hold_one", 32'(pulses - p0), 32'd1);

        // Player deactivated while waiting cancels the request.
        do_reset();
        p0 = pulses;
        bus.shots_active = 8'hFF;
        press(); step(4);
        bus.player_active = 1'b0;
        step(2);
        bus.shots_active = 8'h00;
        step(6);
        check("cancel_none", 32'(pulses - p0), 32'd0);
        check("cancel_idle", 32'(bus.busy), 32'h0);

        // Reset during the launch cycle aborts the pulse.
        do_reset();
        p0 = pulses;
        bus.shoot = 1'b1;
        step(2);
        #2 resetN = 1'b0;
        #1;
        check("abort_deploy", 32'(bus.deploy_shot), 32'h0);
        check("abort_free_count", 32'(bus.free_count), 32'd8);
        check("abort_busy", 32'(bus.busy), 32'h0);
        bus.shoot = 1'b0;
        step(2);
        resetN = 1'b1;
        step(5);
        check("abort_no_pulse", 32'(pulses - p0), 32'd0);

        // Randomized traffic against the model.
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            bus.startOfFrame = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 3) == 0) bus.shoot = ~bus.shoot;
            bus.player_active = ($urandom_range(0, 15) != 0);
            if ($urandom_range(0, 5) == 0) bus.shots_active = 8'($urandom) & 8'($urandom);
            if ($urandom_range(0, 60) == 0) bus.shots_active = 8'hFF;
            step(1);
        end
        check("random_some_pulses", 32'(pulses > 10), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
